// File: rtl/dcnn_io_pkg.sv
// Shared definitions for the decompressed-word memory writer.
package dcnn_io_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ADDR_W = 16;

  // Transfer sequencing states of the memory writer.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wr_state_e;

endpackage

// File: rtl/word_fifo.sv
// Synchronous staging FIFO with full/empty flags and a synchronous flush.
// The read port shows the head entry; it reads as zero while the FIFO is empty.
module word_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic                push_ok;
  logic                pop_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

  // Next pointer values; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mem_writer.sv
// Memory writer: accepts decompressed words, stages them in a small FIFO
// and writes them to consecutive addresses with a request/ack handshake.
module mem_writer
  import dcnn_io_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done
);

  wr_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [ADDR_W-1:0] accepted_q, accepted_d;
  logic [ADDR_W-1:0] written_q, written_d;
  logic [ADDR_W-1:0] written_inc;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_flush;
  logic [DATA_W-1:0] fifo_head;
  logic              push;
  logic              pop;
  logic              running;

  assign running     = (state_q == ST_RUN);
  assign written_inc = written_q + 1'b1;

  // Abort masks both handshakes in the cycle it is seen, so a coinciding
  // ack never counts as a completed write.
  assign in_ready = running && !fifo_full && (accepted_q < count_q) && !abort;
  assign mem_we   = running && !fifo_empty && !abort;
  assign push     = in_valid && in_ready;
  assign pop      = mem_we && mem_ack;

  assign mem_addr = addr_q;
  assign mem_data = fifo_head;
  assign busy     = running;
  assign done     = (state_q == ST_DONE);

  word_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (fifo_flush),
    .push    (push),
    .pop     (pop),
    .wr_data (in_data),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Next-state, address and word-counter logic for the transfer sequence.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    count_d    = count_q;
    accepted_d = accepted_q;
    written_d  = written_q;
    fifo_flush = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d     = base_addr;
          count_d    = word_count;
          accepted_d = '0;
          written_d  = '0;
          state_d    = (word_count == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          fifo_flush = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          if (push) accepted_d = accepted_q + 1'b1;
          if (pop) begin
            written_d = written_inc;
            addr_d    = addr_q + 1'b1;
            if (written_inc == count_q) state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, address and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      accepted_q <= '0;
      written_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      count_q    <= count_d;
      accepted_q <= accepted_d;
      written_q  <= written_d;
    end
  end

endmodule

// File: tb/tb_mem_writer.sv
// Directed self-checking bench for mem_writer.
module tb_mem_writer;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ack;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_writer #(
    .DATA_W     (16),
    .ADDR_W     (16),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    logic        s;
    logic        a;
    logic [15:0] base;
    logic [15:0] cnt;
    logic        iv;
    logic [15:0] din;
    logic        ack;
    logic        e_rdy;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_data;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic we,
                         input logic [15:0] ad, input logic [15:0] da,
                         input logic bs, input logic dn);
    chk({tag, ".in_ready"}, 16'(in_ready), 16'(rdy));
    chk({tag, ".mem_we"},   16'(mem_we),   16'(we));
    chk({tag, ".mem_addr"}, mem_addr,      ad);
    chk({tag, ".mem_data"}, mem_data,      da);
    chk({tag, ".busy"},     16'(busy),     16'(bs));
    chk({tag, ".done"},     16'(done),     16'(dn));
  endtask

  task automatic drive(input logic s, input logic a, input logic [15:0] b,
                       input logic [15:0] c, input logic iv,
                       input logic [15:0] d, input logic ak);
    start      = s;
    abort      = a;
    base_addr  = b;
    word_count = c;
    in_valid   = iv;
    in_data    = d;
    mem_ack    = ak;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] occ, sent, wr;
    logic        e_rdy, e_we, ack;

    // start, abort, base, cnt, in_valid, in_data, ack | rdy, we, addr, data, busy, done
    // basic 3-word transfer
    vt[0]  = '{H, L, 16'h0100, 16'd3, L, 16'h0000, H, L, L, 16'h0000, 16'h0000, L, L};
    vt[1]  = '{L, L, 16'h0000, 16'd0, H, 16'hAAAA, H, H, L, 16'h0100, 16'h0000, H, L};
    vt[2]  = '{L, L, 16'h0000, 16'd0, H, 16'hBBBB, H, H, H, 16'h0100, 16'hAAAA, H, L};
    vt[3]  = '{L, L, 16'h0000, 16'd0, H, 16'hCCCC, H, H, H, 16'h0101, 16'hBBBB, H, L};
    vt[4]  = '{L, L, 16'h0000, 16'd0, H, 16'hDDDD, H, L, H, 16'h0102, 16'hCCCC, H, L};
    vt[5]  = '{L, L, 16'h0000, 16'd0, L, 16'h0000, H, L, L, 16'h0103, 16'h0000, L, H};
    vt[6]  = '{L, L, 16'h0000, 16'd0, L, 16'h0000, H, L, L, 16'h0103, 16'h0000, L, L};
    // zero-length transfer, then abort while idle
    vt[7]  = '{H, L, 16'h0200, 16'd0, L, 16'h0000, H, L, L, 16'h0103, 16'h0000, L, L};
    vt[8]  = '{L, L, 16'h0000, 16'd0, H, 16'hEEEE, H, L, L, 16'h0200, 16'h0000, L, H};
    vt[9]  = '{L, H, 16'h0000, 16'd0, L, 16'h0000, H, L, L, 16'h0200, 16'h0000, L, L};
    // address wrap; start in RUN and start/abort in DONE ignored
    vt[10] = '{H, L, 16'hFFFE, 16'd4, L, 16'h0000, H, L, L, 16'h0200, 16'h0000, L, L};
    vt[11] = '{L, L, 16'h0000, 16'd0, H, 16'h0001, H, H, L, 16'hFFFE, 16'h0000, H, L};
    vt[12] = '{L, L, 16'h0000, 16'd0, H, 16'h0002, H, H, H, 16'hFFFE, 16'h0001, H, L};
    vt[13] = '{H, L, 16'h5555, 16'd9, H, 16'h0003, H, H, H, 16'hFFFF, 16'h0002, H, L};
    vt[14] = '{L, L, 16'h0000, 16'd0, H, 16'h0004, H, H, H, 16'h0000, 16'h0003, H, L};
    vt[15] = '{L, L, 16'h0000, 16'd0, L, 16'h0000, H, L, H, 16'h0001, 16'h0004, H, L};
    vt[16] = '{H, H, 16'h1234, 16'd2, L, 16'h0000, H, L, L, 16'h0002, 16'h0000, L, H};
    vt[17] = '{L, L, 16'h0000, 16'd0, L, 16'h0000, H, L, L, 16'h0002, 16'h0000, L, L};

    rst = 1'b0;
    drive(L, L, 16'h0, 16'h0, L, 16'h0, L);
    #2;
    chk_out("reset", L, L, 16'h0000, 16'h0000, L, L);
    @(posedge clk);
    #1;
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].s, vt[i].a, vt[i].base, vt[i].cnt, vt[i].iv, vt[i].din, vt[i].ack);
      #1;
      chk_out($sformatf("vec%0d", i), vt[i].e_rdy, vt[i].e_we, vt[i].e_addr,
              vt[i].e_data, vt[i].e_busy, vt[i].e_done);
      tick();
    end

    // Back-pressure: 6 words, ack held low for 10 cycles, FIFO depth 4.
    drive(H, L, 16'h0300, 16'd6, L, 16'h0, L);
    #1;
    tick();
    occ = '0; sent = '0; wr = '0;
    for (int c = 0; c < 30 && wr < 6; c++) begin
      ack = (c >= 10);
      drive(L, L, 16'h0, 16'h0, H, 16'h1000 + sent, ack);
      #1;
      e_rdy = (occ < 4) && (sent < 6);
      e_we  = (occ > 0);
      chk($sformatf("bp%0d.in_ready", c), 16'(in_ready), 16'(e_rdy));
      chk($sformatf("bp%0d.mem_we", c), 16'(mem_we), 16'(e_we));
      if (e_we) begin
        chk($sformatf("bp%0d.mem_addr", c), mem_addr, 16'h0300 + wr);
        chk($sformatf("bp%0d.mem_data", c), mem_data, 16'h1000 + wr);
      end
      tick();
      if (e_rdy) begin
        sent = sent + 1'b1;
        occ  = occ + 1'b1;
      end
      if (e_we && ack) begin
        occ = occ - 1'b1;
        wr  = wr + 1'b1;
      end
    end
    drive(L, L, 16'h0, 16'h0, L, 16'h0, L);
    #1;
    chk_out("bp_done", L, L, 16'h0306, 16'h0000, L, H);
    tick();
    chk_out("bp_idle", L, L, 16'h0306, 16'h0000, L, L);

    // Abort after 2 of 5 words written, then a fresh 1-word transfer.
    drive(H, L, 16'h0400, 16'd5, L, 16'h0, H);
    #1;
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(L, L, 16'h0, 16'h0, H, 16'h2000 + 16'(c), H);
      #1;
      chk($sformatf("ab%0d.in_ready", c), 16'(in_ready), 16'd1);
      chk($sformatf("ab%0d.mem_we", c), 16'(mem_we), 16'(c > 0));
      tick();
    end
    drive(L, H, 16'h0, 16'h0, H, 16'h2003, H);
    #1;
    chk("ab_cycle.mem_we", 16'(mem_we), 16'd0);
    chk("ab_cycle.in_ready", 16'(in_ready), 16'd0);
    chk("ab_cycle.busy", 16'(busy), 16'd1);
    tick();
    drive(L, L, 16'h0, 16'h0, H, 16'h2004, H);
    #1;
    chk_out("ab_idle0", L, L, 16'h0402, 16'h0000, L, L);
    tick();
    chk_out("ab_idle1", L, L, 16'h0402, 16'h0000, L, L);
    drive(H, L, 16'h0500, 16'd1, L, 16'h0, H);
    #1;
    tick();
    drive(L, L, 16'h0, 16'h0, H, 16'h3333, H);
    #1;
    chk_out("ab_re1", H, L, 16'h0500, 16'h0000, H, L);
    tick();
    drive(L, L, 16'h0, 16'h0, H, 16'h4444, H);
    #1;
    chk_out("ab_re2", L, H, 16'h0500, 16'h3333, H, L);
    tick();
    drive(L, L, 16'h0, 16'h0, L, 16'h0, H);
    #1;
    chk_out("ab_re3", L, L, 16'h0501, 16'h0000, L, H);
    tick();

    // Reset with 3 words buffered; nothing written afterwards without start.
    drive(H, L, 16'h0600, 16'd8, L, 16'h0, L);
    #1;
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(L, L, 16'h0, 16'h0, H, 16'h5000 + 16'(c), L);
      #1;
      tick();
    end
    chk("rst_pre.mem_we", 16'(mem_we), 16'd1);
    drive(L, L, 16'h0, 16'h0, H, 16'h5003, H);
    rst = 1'b0;
    #1;
    chk_out("rst_now", L, L, 16'h0000, 16'h0000, L, L);
    tick();
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive(L, L, 16'h0, 16'h0, H, 16'h6000, H);
      #1;
      chk_out($sformatf("rst_after%0d", c), L, L, 16'h0000, 16'h0000, L, L);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
